// File: rtl/jk_ff_pkg.sv
// Shared definitions for the JK flip-flop bank.
// Optional simulation checks in jk_ff are enabled by defining JK_FF_ASSERT_EN.
package jk_ff_pkg;

    // Per-bit operation, encoded as {J,K}
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_mode_e;

    // Value every bit takes while reset is asserted
    localparam logic JK_RST_VAL = 1'b0;

    // Supported bank widths
    localparam int unsigned JK_WIDTH_MIN = 1;
    localparam int unsigned JK_WIDTH_MAX = 64;

    // Next state of one bit for a given mode and current state
    function automatic logic jk_next(input jk_mode_e mode, input logic q);
        logic nxt;
        nxt = q;
        case (mode)
            JK_HOLD: nxt = q;
            JK_CLR:  nxt = 1'b0;
            JK_SET:  nxt = 1'b1;
            JK_TGL:  nxt = ~q;
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// Single-bit JK flip-flop with synchronous active-low reset.
module jk_ff_cell
    import jk_ff_pkg::*;
(
    input  logic CLK,
    input  logic RST_n,
    input  logic J,
    input  logic K,
    output logic Q
);

    logic     r_q;
    jk_mode_e w_mode;
    logic     w_q_nxt;

    // Decode J/K into an operation and compute the candidate next state
    always_comb begin
        w_mode  = jk_mode_e'({J, K});
        w_q_nxt = jk_next(w_mode, r_q);
    end

    // State register; reset dominates J/K
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_q <= JK_RST_VAL;
        end else begin
            r_q <= w_q_nxt;
        end
    end

    assign Q = r_q;

endmodule

// File: rtl/jk_ff.sv
// Bank of WIDTH independent JK flip-flops with true and complement outputs.
// Define JK_FF_ASSERT_EN to compile in simulation-only consistency checks.
module jk_ff
    import jk_ff_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q2
);

    logic [WIDTH-1:0] w_q;

    // One independent cell per bit
    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_cell
        jk_ff_cell u_cell (
            .CLK   (CLK),
            .RST_n (RST_n),
            .J     (J[gi]),
            .K     (K[gi]),
            .Q     (w_q[gi])
        );
    end

    // Both outputs come from the same state; the complement is never a separate flop
    assign Q1 = w_q;
    assign Q2 = ~w_q;

`ifdef JK_FF_ASSERT_EN
    logic r_seen_rst;
    logic r_rst_prev;

    // Remember whether reset has ever been applied and whether the last edge was a reset edge
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_seen_rst <= 1'b1;
        end
        r_rst_prev <= (RST_n === 1'b0);
    end

    // Complement output must mirror the true output bit for bit
    always_comb begin
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (!$isunknown(Q1[i]) && (Q2[i] !== ~Q1[i])) begin
                $error("jk_ff: Q2 is not ~Q1 at bit %0d", i);
            end
        end
    end

    // Edge-time checks: reset result and known inputs once out of the undefined start-up period
    always @(posedge CLK) begin
        if (r_rst_prev === 1'b1) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (Q1[i] !== JK_RST_VAL) begin
                    $error("jk_ff: Q1 not cleared after reset at bit %0d", i);
                end
            end
        end
        if (r_seen_rst === 1'b1) begin
            if ($isunknown(RST_n)) begin
                $error("jk_ff: X on RST_n at bit %0d", 0);
            end
            for (int i = 0; i < int'(WIDTH); i++) begin
                if ($isunknown(J[i])) begin
                    $error("jk_ff: X on J at bit %0d", i);
                end
                if ($isunknown(K[i])) begin
                    $error("jk_ff: X on K at bit %0d", i);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_jk_ff.sv
// Self-checking bench for jk_ff at widths 1, 4 and 64.
module tb_jk_ff;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        j1, k1;
    logic [3:0]  j4, k4;
    logic [63:0] j64, k64;
    logic        q1_w1, q2_w1;
    logic [3:0]  q1_w4, q2_w4;
    logic [63:0] q1_w64, q2_w64;

    int total = 0;
    int bad   = 0;

    // Reference state of each bank
    logic [63:0] m1, m4, m64;

    always #5 CLK = ~CLK;

    jk_ff #(.WIDTH(1)) u_dut_w1 (
        .CLK(CLK), .RST_n(RST_n), .J(j1), .K(k1), .Q1(q1_w1), .Q2(q2_w1)
    );
    jk_ff #(.WIDTH(4)) u_dut_w4 (
        .CLK(CLK), .RST_n(RST_n), .J(j4), .K(k4), .Q1(q1_w4), .Q2(q2_w4)
    );
    jk_ff #(.WIDTH(64)) u_dut_w64 (
        .CLK(CLK), .RST_n(RST_n), .J(j64), .K(k64), .Q1(q1_w64), .Q2(q2_w64)
    );

    // Behavioural rule: reset clears; otherwise set, clear, toggle or hold per bit
    function automatic logic [63:0] ref_next(input logic [63:0] q, input logic [63:0] j,
                                             input logic [63:0] k, input logic rst_n);
        logic [63:0] r;
        r = '0;
        if (!rst_n) return '0;
        for (int i = 0; i < 64; i++) begin
            if (j[i] && k[i])  r[i] = ~q[i];
            else if (j[i])     r[i] = 1'b1;
            else if (k[i])     r[i] = 1'b0;
            else               r[i] = q[i];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/w1_q1"},  {63'b0, q1_w1},  m1 & 64'h1);
        chk({tag, "/w1_q2"},  {63'b0, q2_w1},  ~m1 & 64'h1);
        chk({tag, "/w4_q1"},  {60'b0, q1_w4},  m4 & 64'hF);
        chk({tag, "/w4_q2"},  {60'b0, q2_w4},  ~m4 & 64'hF);
        chk({tag, "/w64_q1"}, q1_w64,          m64);
        chk({tag, "/w64_q2"}, q2_w64,          ~m64);
    endtask

    // Advance one edge using the inputs currently driven, then compare
    task automatic tick(input string tag);
        m1  = ref_next(m1,  {63'b0, j1}, {63'b0, k1}, RST_n) & 64'h1;
        m4  = ref_next(m4,  {60'b0, j4}, {60'b0, k4}, RST_n) & 64'hF;
        m64 = ref_next(m64, j64, k64, RST_n);
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    initial begin
        m1 = '0; m4 = '0; m64 = '0;

        // Reset wins over set
        RST_n = 1'b0; j1 = 1'b1; k1 = 1'b0; j4 = 4'hF; k4 = 4'h0;
        j64 = '1; k64 = '0;
        tick("reset");

        // Set, then clear; mixed per-bit pattern on the 4-bit bank
        RST_n = 1'b1; j1 = 1'b1; k1 = 1'b0; j4 = 4'b1010; k4 = 4'b0110;
        j64 = {$urandom, $urandom}; k64 = {$urandom, $urandom};
        tick("set");
        j1 = 1'b0; k1 = 1'b1;
        j64 = {$urandom, $urandom}; k64 = {$urandom, $urandom};
        tick("clr");

        // Hold for three edges after setting, with a J/K glitch between edges
        j1 = 1'b1; k1 = 1'b0; j4 = 4'hF; k4 = 4'h0; j64 = '1; k64 = '0;
        tick("pre_hold");
        j1 = 1'b0; k1 = 1'b0; j4 = 4'h0; k4 = 4'h0; j64 = '0; k64 = '0;
        for (int n = 0; n < 3; n++) begin
            #2;
            j1 = 1'b1; k1 = 1'b1; j4 = 4'hF; k4 = 4'hF; j64 = '1; k64 = '1;
            #3;
            check_all("glitch_mid");
            j1 = 1'b0; k1 = 1'b0; j4 = 4'h0; k4 = 4'h0; j64 = '0; k64 = '0;
            tick("hold");
        end

        // Toggle from zero: expect 1,0,1,0
        j1 = 1'b0; k1 = 1'b1; j4 = 4'h0; k4 = 4'hF; j64 = '0; k64 = '1;
        tick("pre_tgl");
        j1 = 1'b1; k1 = 1'b1; j4 = 4'hF; k4 = 4'hF; j64 = '1; k64 = '1;
        for (int n = 0; n < 4; n++) tick("toggle");

        // Reset during toggling, then toggling resumes from zero
        tick("toggle_pre_rst");
        RST_n = 1'b0;
        tick("mid_reset");
        RST_n = 1'b1;
        tick("resume1");
        tick("resume2");

        // Randomized operation with occasional reset
        for (int n = 0; n < 60; n++) begin
            RST_n = ($urandom_range(7) != 0);
            j1  = 1'($urandom); k1 = 1'($urandom);
            j4  = 4'($urandom); k4 = 4'($urandom);
            j64 = {$urandom, $urandom}; k64 = {$urandom, $urandom};
            tick("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
